mesh_edge_feeder: RTL and testbench
===================================

Name: mesh_edge_feeder

Overview:
- Parametrised edge-of-mesh input block that replaces the fixed 4-entry, single-lane feeder.
- Buffers a burst of up to DEPTH vectors, each LANES words wide, through a valid/ready handshake.
- Replays the burst into the mesh with either a systolic staircase skew (lane i delayed i cycles) or broadcast alignment.
- Drives the north or the west edge bus, and holds the configuration word for the adjacent processing element (PE) row/column.

Parameters:
- DATA_W, 32, width of one lane word
- LANES, 4, number of edge lanes (mesh rows or columns)
- DEPTH, 8, maximum vectors per burst (power of two, at least 2)
- CFG_W, 64, configuration word width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_load  in  1  capture cfg_in, cfg_dir and cfg_systolic
- cfg_in  in  CFG_W  configuration word
- cfg_dir  in  1  edge select: 1 = west, 0 = north
- cfg_systolic  in  1  1 = staircase skew, 0 = broadcast
- start  in  1  begin a burst
- in_valid  in  1  input vector valid
- in_ready  out  1  feeder accepts a vector
- in_data  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
- in_last  in  1  final vector of the burst
- out_north  out  LANES*DATA_W  north edge data
- out_west  out  LANES*DATA_W  west edge data
- out_valid  out  LANES  per-lane word valid on the selected edge
- cfg_out  out  CFG_W  configuration word to the mesh
- busy  out  1  high in FILL or DRAIN
- done  out  1  one-cycle pulse at the end of DRAIN

Behaviour:
- Reset (asynchronous, reset_n = 0): state IDLE; all outputs 0; count, t, dir_q and sys_q all 0; buffer contents are don't-care.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - cfg_load = 1 registers cfg_out, dir_q and sys_q; cfg_load is ignored in every other state.
  - start = 1 moves to FILL and clears count.
- FILL:
  - in_ready = 1 while count < DEPTH.
  - Each beat where in_valid and in_ready are both high writes buf[count] and increments count.
  - A beat carrying in_last = 1, or the beat that makes count == DEPTH, moves to DRAIN next cycle with t = 0.
  - in_valid outside FILL is ignored; in_ready stays 0.
- DRAIN:
  - t increments every cycle.
  - Drain length L = count + (sys_q ? LANES-1 : 0).
  - Lane k skew s_k = sys_q ? k : 0.
  - Registered outputs: the cycle after t, lane k carries buf[t-s_k][k] with out_valid[k] = 1 when 0 <= t-s_k < count; otherwise the lane word and out_valid[k] are 0.
  - The selected edge (dir_q) carries data; the other edge bus is held at 0.
  - When t == L-1, move to IDLE; done pulses for one cycle, aligned with the final output word.
- Latency: first out_valid appears 1 cycle after entering DRAIN, i.e. 2 cycles after the accepting beat with in_last.
- start while busy: ignored.
- Width rules: count and t are $clog2(DEPTH+LANES) bits wide; skew compare is unsigned with no wrap.
- Simultaneous cfg_load and start in IDLE: the config is captured and that burst uses the new config.
- Reset mid-burst: immediate return to IDLE with outputs 0; no done pulse.

Optional Feature:
- Macro: FEEDER_STALL_EN.
- Defined:
  - Adds input port mesh_stall.
  - While mesh_stall = 1 in DRAIN, t and all edge outputs hold their values; done is deferred by the stalled cycles.
  - In FILL, mesh_stall has no effect.
- Undefined: no port; DRAIN never pauses.

Decomposition:
- Package mesh_feeder_pkg holds:
  - the state enum (IDLE, FILL, DRAIN)
  - the DIR_NORTH/DIR_WEST constants
  - default DATA_W/CFG_W localparams
- Sub-module feeder_buf:
  - DEPTH x LANES*DATA_W register array
  - one write port, plus LANES independent combinational read ports, one per skewed index

Test Plan:
- Systolic, west, LANES = 4: fill 3 vectors (lane k of vector v = 16*v+k) with in_last on the 3rd. Required response:
  - out_valid[0] high for cycles 0..2 of DRAIN, out_valid[3] high for cycles 3..5
  - lane 3 carries 0x03, 0x13, 0x23
  - out_north = 0 throughout
  - done at drain cycle 5
- Broadcast, north, 8 vectors with no in_last: in_ready drops after the 8th beat; all lanes are valid for 8 aligned cycles; done at cycle 7; out_west = 0.
- in_valid toggling 1,0,1,0 during FILL: exactly 2 vectors are stored; a beat with in_valid = 0 does not advance count.
- cfg_load with 0xDEADBEEF_CAFEF00D in IDLE: cfg_out updates next cycle. A second cfg_load during DRAIN leaves cfg_out unchanged.
- reset_n pulled low at DRAIN cycle 2: outputs go to 0 asynchronously; no done; a new start after release runs a clean burst.
- FEEDER_STALL_EN, 3-vector systolic burst with mesh_stall high for drain cycles 2..3: outputs hold during the stall; done is delayed 2 cycles (cycle 7 instead of 5).

Source files
------------

// File: rtl/mesh_feeder_pkg.sv
// rtl/mesh_feeder_pkg.sv - shared state codes, edge selects and default widths for the mesh edge feeder
package mesh_feeder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic DIR_NORTH = 1'b0;
  localparam logic DIR_WEST  = 1'b1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CFG_W  = 64;

endpackage

// File: rtl/feeder_buf.sv
// rtl/feeder_buf.sv - burst vector store with one write port and one combinational read port per lane
module feeder_buf #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic [LANES*AW-1:0]     rd_addr,
  output logic [LANES*DATA_W-1:0] rd_data
);

  // Stored per lane so each skewed read port only touches its own column.
  logic [DATA_W-1:0] mem [DEPTH][LANES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        mem[wr_addr][k] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_rd
    assign rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*AW +: AW]][k];
  end

endmodule

// File: rtl/mesh_edge_feeder.sv
// rtl/mesh_edge_feeder.sv - buffers a burst and replays it skewed or aligned onto the north/west mesh edge
// Optional drain pause input mesh_stall is enabled by defining FEEDER_STALL_EN.
module mesh_edge_feeder
  import mesh_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int CFG_W  = DEF_CFG_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_load,
  input  logic [CFG_W-1:0]        cfg_in,
  input  logic                    cfg_dir,
  input  logic                    cfg_systolic,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
`ifdef FEEDER_STALL_EN
  input  logic                    mesh_stall,
`endif
  output logic [LANES*DATA_W-1:0] out_north,
  output logic [LANES*DATA_W-1:0] out_west,
  output logic [LANES-1:0]        out_valid,
  output logic [CFG_W-1:0]        cfg_out,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(DEPTH + LANES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] SKEW_MAX = CW'(LANES - 1);

  logic [1:0]              state;
  logic [CW-1:0]           count;
  logic [CW-1:0]           t;
  logic                    dir_q;
  logic                    sys_q;
  logic                    stall;
  logic                    accept;
  logic [CW-1:0]           drain_len;
  logic [LANES*AW-1:0]     rd_addr;
  logic [LANES*DATA_W-1:0] rd_data;
  logic [LANES-1:0]        lane_hit;
  logic [LANES*DATA_W-1:0] lane_word;

`ifdef FEEDER_STALL_EN
  assign stall = mesh_stall;
`else
  assign stall = 1'b0;
`endif

  assign in_ready  = (state == ST_FILL) && (count < DEPTH_C);
  assign accept    = in_ready && in_valid;
  assign busy      = (state != ST_IDLE);
  assign drain_len = count + (sys_q ? SKEW_MAX : '0);

  // Lane k reads vector t-skew; the t >= skew guard keeps the unsigned subtract from wrapping.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CW-1:0] skew;
    logic [CW-1:0] idx;
    assign skew        = sys_q ? CW'(k) : '0;
    assign idx         = t - skew;
    assign lane_hit[k] = (t >= skew) && (idx < count);
    assign rd_addr[k*AW +: AW]         = idx[AW-1:0];
    assign lane_word[k*DATA_W +: DATA_W] =
      lane_hit[k] ? rd_data[k*DATA_W +: DATA_W] : '0;
  end

  feeder_buf #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (count[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      t         <= '0;
      dir_q     <= 1'b0;
      sys_q     <= 1'b0;
      cfg_out   <= '0;
      out_north <= '0;
      out_west  <= '0;
      out_valid <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          out_north <= '0;
          out_west  <= '0;
          out_valid <= '0;
          if (cfg_load) begin
            cfg_out <= cfg_in;
            dir_q   <= cfg_dir;
            sys_q   <= cfg_systolic;
          end
          if (start) begin
            state <= ST_FILL;
            count <= '0;
          end
        end
        ST_FILL: begin
          if (accept) begin
            count <= count + 1'b1;
            if (in_last || (count == DEPTH_C - 1'b1)) begin
              state <= ST_DRAIN;
              t     <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            t         <= t + 1'b1;
            out_valid <= lane_hit;
            if (dir_q == DIR_WEST) begin
              out_west  <= lane_word;
              out_north <= '0;
            end else begin
              out_north <= lane_word;
              out_west  <= '0;
            end
            if (t == drain_len - 1'b1) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_edge_feeder.sv
// tb/tb_mesh_edge_feeder.sv - table-driven directed bench for mesh_edge_feeder
module tb_mesh_edge_feeder;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int DP = 8;
  localparam int CFW = 64;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_load = 1'b0;
  logic [CFW-1:0]  cfg_in = '0;
  logic            cfg_dir = 1'b0;
  logic            cfg_systolic = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [LN*DW-1:0] in_data = '0;
  logic            in_last = 1'b0;
`ifdef FEEDER_STALL_EN
  logic            mesh_stall = 1'b0;
`endif
  logic [LN*DW-1:0] out_north;
  logic [LN*DW-1:0] out_west;
  logic [LN-1:0]   out_valid;
  logic [CFW-1:0]  cfg_out;
  logic            busy;
  logic            done;

  mesh_edge_feeder #(
    .DATA_W (DW),
    .LANES  (LN),
    .DEPTH  (DP),
    .CFG_W  (CFW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_load     (cfg_load),
    .cfg_in       (cfg_in),
    .cfg_dir      (cfg_dir),
    .cfg_systolic (cfg_systolic),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
`ifdef FEEDER_STALL_EN
    .mesh_stall   (mesh_stall),
`endif
    .out_north    (out_north),
    .out_west     (out_west),
    .out_valid    (out_valid),
    .cfg_out      (cfg_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         stall;
    logic [3:0]   valid;
    logic [127:0] north;
    logic [127:0] west;
    logic         done;
  } exp_t;

  exp_t tbl [16];
  int   n_tbl;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] vec(input int v);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'(16*v + k);
    return r;
  endfunction

  function automatic logic [127:0] lanes(input logic [31:0] l3, input logic [31:0] l2,
                                         input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic exp_t mk(input logic stall, input logic [3:0] valid, input logic west,
                              input logic [127:0] data, input logic dn);
    exp_t e;
    e.stall = stall;
    e.valid = valid;
    e.north = west ? 128'h0 : data;
    e.west  = west ? data : 128'h0;
    e.done  = dn;
    return e;
  endfunction

  // Staircase response for vectors 0..2, lane k of vector v = 16*v+k, west edge.
  task automatic fill_sys();
    tbl[0] = mk(1'b0, 4'b0001, 1'b1, lanes(32'h00, 32'h00, 32'h00, 32'h00), 1'b0);
    tbl[1] = mk(1'b0, 4'b0011, 1'b1, lanes(32'h00, 32'h00, 32'h01, 32'h10), 1'b0);
    tbl[2] = mk(1'b0, 4'b0111, 1'b1, lanes(32'h00, 32'h02, 32'h11, 32'h20), 1'b0);
    tbl[3] = mk(1'b0, 4'b1110, 1'b1, lanes(32'h03, 32'h12, 32'h21, 32'h00), 1'b0);
    tbl[4] = mk(1'b0, 4'b1100, 1'b1, lanes(32'h13, 32'h22, 32'h00, 32'h00), 1'b0);
    tbl[5] = mk(1'b0, 4'b1000, 1'b1, lanes(32'h23, 32'h00, 32'h00, 32'h00), 1'b1);
    n_tbl = 6;
  endtask

  task automatic start_burst(input logic ld, input logic [63:0] cfg, input logic dir, input logic sys);
    cfg_load     = ld;
    cfg_in       = cfg;
    cfg_dir      = dir;
    cfg_systolic = sys;
    start        = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    start    = 1'b0;
    chk("start_busy", 128'(busy), 128'(1));
  endtask

  task automatic beat(input logic vld, input logic [127:0] data, input logic last);
    chk("fill_ready", 128'(in_ready), 128'(1));
    in_valid = vld;
    in_data  = data;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Entered on the first DRAIN negedge, before any output has been registered.
  task automatic run_table(input string tag);
    chk({tag, "_ready_drain"}, 128'(in_ready), 128'(0));
    chk({tag, "_valid_pre"}, 128'(out_valid), 128'(0));
    for (int i = 0; i < n_tbl; i++) begin
`ifdef FEEDER_STALL_EN
      mesh_stall = tbl[i].stall;
`endif
      @(negedge clk);
      chk($sformatf("%s_valid%0d", tag, i), 128'(out_valid), 128'(tbl[i].valid));
      chk($sformatf("%s_north%0d", tag, i), out_north, tbl[i].north);
      chk($sformatf("%s_west%0d", tag, i), out_west, tbl[i].west);
      chk($sformatf("%s_done%0d", tag, i), 128'(done), 128'(tbl[i].done));
      chk($sformatf("%s_busy%0d", tag, i), 128'(busy), 128'(!tbl[i].done));
    end
`ifdef FEEDER_STALL_EN
    mesh_stall = 1'b0;
`endif
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    chk({tag, "_post_done"}, 128'(done), 128'(0));
    chk({tag, "_post_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_post_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_north", out_north, 128'h0);
    chk("rst_west", out_west, 128'h0);
    chk("rst_cfg", 128'(cfg_out), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(0));
    reset_n = 1'b1;

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    in_data  = vec(9);
    @(negedge clk);
    chk("idle_ready", 128'(in_ready), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    in_valid = 1'b0;

    // Systolic west, 3 vectors; cfg captured together with start
    start_burst(1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b1);
    chk("cfg_capture", 128'(cfg_out), 128'(64'hDEADBEEF_CAFEF00D));
    beat(1'b1, vec(0), 1'b0);
    beat(1'b1, vec(1), 1'b0);
    beat(1'b1, vec(2), 1'b1);
    cfg_load     = 1'b1;
    cfg_in       = 64'h1234;
    cfg_dir      = 1'b0;
    cfg_systolic = 1'b0;
    start        = 1'b1;
    in_valid     = 1'b1;
    fill_sys();
    run_table("sys");
    cfg_load = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    check_idle_after("sys");
    chk("cfg_hold", 128'(cfg_out), 128'(64'hDEADBEEF_CAFEF00D));

    // Broadcast north, full depth without in_last
    start_burst(1'b1, 64'h5, 1'b0, 1'b0);
    for (int v = 0; v < 8; v++) beat(1'b1, vec(v), 1'b0);
    in_valid = 1'b1;
    in_data  = vec(9);
    for (int c = 0; c < 8; c++) tbl[c] = mk(1'b0, 4'hF, 1'b0, vec(c), c == 7);
    n_tbl = 8;
    run_table("bcast");
    in_valid = 1'b0;
    check_idle_after("bcast");
    chk("cfg_reload", 128'(cfg_out), 128'(64'h5));

    // in_valid toggling: the idle beat with in_last must not end or count
    start_burst(1'b1, 64'h6, 1'b1, 1'b0);
    beat(1'b1, vec(4), 1'b0);
    beat(1'b0, vec(9), 1'b1);
    beat(1'b1, vec(5), 1'b1);
    tbl[0] = mk(1'b0, 4'hF, 1'b1, vec(4), 1'b0);
    tbl[1] = mk(1'b0, 4'hF, 1'b1, vec(5), 1'b1);
    n_tbl = 2;
    run_table("toggle");
    check_idle_after("toggle");

    // Reset during drain cycle 2
    start_burst(1'b1, 64'h7, 1'b1, 1'b1);
    beat(1'b1, vec(0), 1'b0);
    beat(1'b1, vec(1), 1'b0);
    beat(1'b1, vec(2), 1'b1);
    fill_sys();
    n_tbl = 3;
    run_table("midrst");
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_west", out_west, 128'h0);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_cfg", 128'(cfg_out), 128'(0));
    @(negedge clk);
    chk("midrst_done", 128'(done), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);
    // Config registers were cleared: a bare start runs north broadcast
    start_burst(1'b0, 64'hF, 1'b1, 1'b1);
    beat(1'b1, vec(6), 1'b0);
    beat(1'b1, vec(7), 1'b1);
    tbl[0] = mk(1'b0, 4'hF, 1'b0, vec(6), 1'b0);
    tbl[1] = mk(1'b0, 4'hF, 1'b0, vec(7), 1'b1);
    n_tbl = 2;
    run_table("clean");
    check_idle_after("clean");

`ifdef FEEDER_STALL_EN
    // Stall during drain cycles 2..3 holds outputs and defers done to cycle 7
    start_burst(1'b1, 64'h8, 1'b1, 1'b1);
    mesh_stall = 1'b1;
    beat(1'b1, vec(0), 1'b0);
    beat(1'b1, vec(1), 1'b0);
    beat(1'b1, vec(2), 1'b1);
    mesh_stall = 1'b0;
    begin
      exp_t s [6];
      fill_sys();
      for (int i = 0; i < 6; i++) s[i] = tbl[i];
      tbl[0] = s[0];
      tbl[1] = s[1];
      tbl[2] = s[1];
      tbl[2].stall = 1'b1;
      tbl[3] = s[1];
      tbl[3].stall = 1'b1;
      for (int i = 2; i < 6; i++) tbl[i+2] = s[i];
      n_tbl = 8;
    end
    run_table("stall");
    check_idle_after("stall");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
